// File: rtl/sc_compute_sequencer_if.sv
// Handshake/control bundle between the compute requester and the SNG-bank
// sequencer: requests in, bank controls and strobes out.
interface sc_compute_sequencer_if #(
  parameter int SEQ_LEN_W = 10,
  parameter int N_L_REG   = 7
);
  logic                 start;
  logic                 dense_mode;
  logic [SEQ_LEN_W-1:0] seq_len;
  logic                 read_req;
  logic                 abort;

  logic                 compute_en;
  logic                 comp_positive_phase;
  logic                 dense_en;
  logic                 read_en;
  logic                 lfsr_load;
  logic [N_L_REG-1:0]   lfsr_sel;
  logic                 busy;
  logic                 phase_done;
  logic                 done;
  logic                 read_ack;

  modport master (
    output start, dense_mode, seq_len, read_req, abort,
    input  compute_en, comp_positive_phase, dense_en, read_en,
    input  lfsr_load, lfsr_sel, busy, phase_done, done, read_ack
  );

  modport slave (
    input  start, dense_mode, seq_len, read_req, abort,
    output compute_en, comp_positive_phase, dense_en, read_en,
    output lfsr_load, lfsr_sel, busy, phase_done, done, read_ack
  );
endinterface

// File: rtl/sc_compute_sequencer.sv
// SNG/LFSR bank compute sequencer: optional reseed, +/- phase windows, read.
// Define SC_LFSR_RELOAD_EN to reseed every row LFSR before each compute.
module sc_compute_sequencer #(
  parameter int SEQ_LEN_W = 10,
  parameter int N_LFSR    = 81,
  parameter int N_L_REG   = 7
) (
  input logic                    CLK,
  input logic                    RESET_N,
  sc_compute_sequencer_if.slave  bus
);
  localparam int CNT_W =
    (SEQ_LEN_W > N_L_REG) ? SEQ_LEN_W : N_L_REG;

  if ((2 ** N_L_REG) < N_LFSR) begin : g_sel_chk
    $error("lfsr_sel too narrow for N_LFSR");
  end

`ifdef SC_LFSR_RELOAD_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_POS, S_GAP, S_NEG, S_FIN, S_READ
  } state_t;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N_LFSR - 1);
`else
  typedef enum logic [2:0] {
    S_IDLE, S_POS, S_GAP, S_NEG, S_FIN, S_READ
  } state_t;
`endif

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [SEQ_LEN_W-1:0] len_q, len_n;
  logic                 dense_q, dense_n;
  logic [CNT_W-1:0]     last, last_n;

  // Binary compute collapses each phase to a single cycle.
  function automatic logic [CNT_W-1:0] last_idx(
    input logic                 d,
    input logic [SEQ_LEN_W-1:0] l
  );
    return d ? CNT_W'(l - SEQ_LEN_W'(1)) : '0;
  endfunction

  assign last   = last_idx(dense_q, len_q);
  assign last_n = last_idx(dense_n, len_n);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
    dense_n = dense_q;
    if (bus.abort) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            dense_n = bus.dense_mode;
            len_n   = (bus.seq_len == '0) ?
                      SEQ_LEN_W'(1) : bus.seq_len;
            cnt_n   = '0;
`ifdef SC_LFSR_RELOAD_EN
            state_n = S_LOAD;
`else
            state_n = S_POS;
`endif
          end else if (bus.read_req) begin
            state_n = S_READ;
          end
        end
`ifdef SC_LFSR_RELOAD_EN
        S_LOAD: begin
          if (cnt == LOAD_LAST) begin
            state_n = S_POS;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
`endif
        S_POS: begin
          if (cnt == last) begin
            state_n = S_GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          state_n = S_NEG;
          cnt_n   = '0;
        end
        S_NEG: begin
          if (cnt == last) begin
            state_n = S_FIN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_FIN:   state_n = S_IDLE;
        S_READ:  state_n = S_IDLE;
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave a flop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state                   <= S_IDLE;
      cnt                     <= '0;
      len_q                   <= '0;
      dense_q                 <= 1'b0;
      bus.busy                <= 1'b0;
      bus.compute_en          <= 1'b0;
      bus.comp_positive_phase <= 1'b0;
      bus.dense_en            <= 1'b0;
      bus.read_en             <= 1'b0;
      bus.read_ack            <= 1'b0;
      bus.phase_done          <= 1'b0;
      bus.done                <= 1'b0;
    end else begin
      state                   <= state_n;
      cnt                     <= cnt_n;
      len_q                   <= len_n;
      dense_q                 <= dense_n;
      bus.busy                <= (state_n != S_IDLE);
      bus.compute_en          <= (state_n == S_POS) ||
                                 (state_n == S_NEG);
      bus.comp_positive_phase <= (state_n == S_POS);
      bus.dense_en            <= dense_n &&
                                 (state_n != S_IDLE) &&
                                 (state_n != S_READ);
      bus.read_en             <= (state_n == S_READ);
      bus.read_ack            <= (state_n == S_READ);
      bus.phase_done          <= ((state_n == S_POS) ||
                                  (state_n == S_NEG)) &&
                                 (cnt_n == last_n);
      bus.done                <= (state_n == S_FIN);
    end
  end

`ifdef SC_LFSR_RELOAD_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bus.lfsr_load <= 1'b0;
      bus.lfsr_sel  <= '0;
    end else begin
      bus.lfsr_load <= (state_n == S_LOAD);
      bus.lfsr_sel  <= (state_n == S_LOAD) ?
                       cnt_n[N_L_REG-1:0] : '0;
    end
  end
`else
  assign bus.lfsr_load = 1'b0;
  assign bus.lfsr_sel  = '0;
`endif

endmodule

// File: tb/tb_sc_compute_sequencer.sv
// Directed bench for sc_compute_sequencer: per-cycle expected output trace
// queued at stimulus time, popped and compared one entry per clock.
module tb_sc_compute_sequencer;
`ifdef SC_LFSR_RELOAD_EN
  localparam int NL = 81;
`else
  localparam int NL = 0;
`endif

  typedef struct packed {
    logic       busy;
    logic       ce;
    logic       pos;
    logic       dense;
    logic       rd;
    logic       ld;
    logic [6:0] sel;
    logic       pd;
    logic       dn;
    logic       ack;
  } obs_t;

  logic clk;
  logic rst_n;

  sc_compute_sequencer_if #(.SEQ_LEN_W(10), .N_L_REG(7)) bus ();

  sc_compute_sequencer #(
    .SEQ_LEN_W (10),
    .N_LFSR    (81),
    .N_L_REG   (7)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  exp_q[$];
  int    n_chk;
  int    n_fail;
  int    cyc;
  int    done_cyc;
  int    n_done;
  int    t_start;
  string tag;

  function automatic obs_t sample();
    obs_t o;
    o.busy  = bus.busy;
    o.ce    = bus.compute_en;
    o.pos   = bus.comp_positive_phase;
    o.dense = bus.dense_en;
    o.rd    = bus.read_en;
    o.ld    = bus.lfsr_load;
    o.sel   = bus.lfsr_sel;
    o.pd    = bus.phase_done;
    o.dn    = bus.done;
    o.ack   = bus.read_ack;
    return o;
  endfunction

  task automatic check(input string t, input obs_t o, input obs_t e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", t, cyc, o, e);
    end
  endtask

  task automatic check_int(input string t, input int o, input int e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", t, o, e);
    end
  endtask

  task automatic tick();
    obs_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done === 1'b1) begin
      done_cyc = cyc;
      n_done++;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, sample(), e);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 2000) begin
      tick();
      g++;
    end
    check_int({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  // Expected trace from the cycle after start; limit<0 keeps it all.
  task automatic push_compute(input bit d, input int len,
                              input int limit);
    obs_t tmp[$];
    obs_t e;
    int   l;
    l = d ? ((len == 0) ? 1 : len) : 1;
    for (int i = 0; i < NL; i++) begin
      e = '0; e.busy = 1; e.dense = d; e.ld = 1; e.sel = 7'(i);
      tmp.push_back(e);
    end
    for (int i = 0; i < l; i++) begin
      e = '0; e.busy = 1; e.ce = 1; e.pos = 1; e.dense = d;
      e.pd = (i == l - 1);
      tmp.push_back(e);
    end
    e = '0; e.busy = 1; e.dense = d;
    tmp.push_back(e);
    for (int i = 0; i < l; i++) begin
      e = '0; e.busy = 1; e.ce = 1; e.dense = d;
      e.pd = (i == l - 1);
      tmp.push_back(e);
    end
    e = '0; e.busy = 1; e.dense = d; e.dn = 1;
    tmp.push_back(e);
    tmp.push_back('0);
    for (int i = 0; i < tmp.size(); i++)
      if (limit < 0 || i < limit) exp_q.push_back(tmp[i]);
  endtask

  task automatic issue_start(input bit d, input int len, input bit rr);
    bus.start      = 1'b1;
    bus.dense_mode = d;
    bus.seq_len    = 10'(len);
    bus.read_req   = rr;
    t_start        = cyc;
    tick();
    bus.start      = 1'b0;
    bus.dense_mode = ~d;
    bus.seq_len    = 10'($urandom);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; done_cyc = 0; n_done = 0;
    t_start = 0; tag = "reset";
    bus.start = 0; bus.dense_mode = 0; bus.seq_len = '0;
    bus.read_req = 0; bus.abort = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", sample(), '0);
    #2 rst_n = 1'b1;
    push_idle(2);
    tick(); tick();

    tag = "dense8";
    push_compute(1, 8, -1);
    issue_start(1, 8, 0);
    drain();
    check_int("dense8_lat", done_cyc - t_start, NL + 2 * 8 + 2);

    tag = "bin100";
    push_compute(0, 100, -1);
    issue_start(0, 100, 0);
    drain();
    check_int("bin100_lat", done_cyc - t_start, NL + 4);

    tag = "len0";
    push_compute(1, 0, -1);
    issue_start(1, 0, 0);
    drain();
    check_int("len0_lat", done_cyc - t_start, NL + 4);

    tag = "start_read";
    push_compute(1, 3, -1);
    begin
      obs_t e;
      e = '0; e.busy = 1; e.rd = 1; e.ack = 1;
      exp_q.push_back(e);
    end
    push_idle(1);
    issue_start(1, 3, 1);
    for (int g = 0; g < 2000 && exp_q.size() > 1; g++) tick();
    bus.read_req = 1'b0;
    tick();
    drain();

    tag = "abort";
    n_done = 0;
    push_compute(1, 8, NL + 8 + 1 + 3);
    push_idle(2);
    issue_start(1, 8, 0);
    for (int g = 0; g < 2000 && exp_q.size() > 2; g++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    drain();
    check_int("abort_no_done", n_done, 0);

    tag = "after_abort";
    push_compute(1, 5, -1);
    issue_start(1, 5, 0);
    drain();
    check_int("after_abort_lat", done_cyc - t_start, NL + 2 * 5 + 2);

    tag = "idle_abort_start";
    push_idle(2);
    bus.start = 1'b1; bus.abort = 1'b1;
    bus.dense_mode = 1'b1; bus.seq_len = 10'd4;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();
    drain();

    tag = "rst_mid";
    push_compute(1, 8, (NL > 0) ? 41 : 3);
    issue_start(1, 8, 0);
    for (int g = 0; g < 2000 && exp_q.size() > 0; g++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", sample(), '0);
    tick();
    check("rst_held", sample(), '0);
    #2 rst_n = 1'b1;
    push_idle(2);
    tick(); tick();
    drain();

    tag = "final";
    push_compute(0, 7, -1);
    issue_start(0, 7, 0);
    drain();
    check_int("final_lat", done_cyc - t_start, NL + 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
